sevenseg_scan_driver: RTL and testbench
=======================================

Name: sevenseg_scan_driver

Overview:
- Downstream display stage for the arithmetic core.
- Latches the core's result word when the core's load strobe fires (the core's busy falling edge).
- Time-multiplexes the word as hex digits onto a common-anode 8-digit 7-segment display.
- Drives active-low segments, decimal point and anodes, with a per-slot anti-ghosting blank window.

Parameters:
- DIGITS, 8: number of digits; value width is 4*DIGITS.
- REFRESH_DIV, 100000: clk cycles per digit slot; must be ≥ 2.
- BLANK_CYCLES, 2: cycles at the start of each slot with all anodes off; must be < REFRESH_DIV.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- load  in  1  latch value/dot_mask this edge
- value  in  4*DIGITS  hex word; digit i = value[4i+3:4i]
- dot_mask  in  DIGITS  1 = dot lit on digit i
- enable  in  1  0 = display dark; scanning continues
- segments  out  7  {g,f,e,d,c,b,a}, active-low
- dots  out  1  decimal point, active-low
- an  out  DIGITS  anodes, active-low, one-hot-low
- frame  out  1  1-cycle pulse when digit index wraps to 0

Behaviour:
- Reset values: shadow value 0, shadow dots 0, prescaler 0, idx 0, segments 7'h7F, dots 1, an all 1s, frame 0.
- Reset mid-scan discards the latched word.
- Latch: load=1 at a posedge copies value and dot_mask into the shadow registers at that edge.
- Load takes effect for the currently selected digit from that point on; no waiting for a frame boundary.
- load held high re-latches every cycle.
- Prescaler: counts 0..REFRESH_DIV-1. At REFRESH_DIV-1 it wraps to 0 and idx advances.
- idx advance: idx = (idx==DIGITS-1) ? 0 : idx+1.
- frame=1 in the cycle after idx wraps DIGITS-1→0.
- All outputs are registered. Pins reflect (prescaler, idx, shadow, enable) sampled the previous edge, i.e. 1-cycle latency.
- Dark condition: prescaler < BLANK_CYCLES, or enable=0.
  - Pins: an all 1s, segments 7'h7F, dots 1.
- Lit condition (otherwise):
  - an[idx]=0, all other anode bits 1.
  - segments = decode(shadow digit idx).
  - dots = ~shadow_dot[idx].
- Decode table, hex, active-low: 0:40 1:79 2:24 3:30 4:19 5:12 6:02 7:78 8:00 9:10 A:08 b:03 C:46 d:21 E:06 F:0E.
- Never more than one anode low in any cycle, including around reset and enable transitions.
- Simultaneous load and slot change: the new digit shows the newly latched nibble.
- Simultaneous enable rise and blank window: blank wins.

Optional Feature:
- Macro LEADING_ZERO_BLANK_EN.
- Defined:
  - In the lit condition, digit i > 0 displays segments 7'h7F when every shadow digit j ≥ i is zero.
  - The anode is still driven low, so timing is unchanged.
  - Digit 0 is always shown.
  - dots still follow dot_mask.
  - Example: value 0x00000305 shows "305", with digits 7..3 dark.
- Undefined: all digits always decoded, so zeros show as 40.

Test Plan:
- Sim parameters: REFRESH_DIV=4, BLANK_CYCLES=1, DIGITS=8.
- Reset test: assert rst 3 cycles -> an=FF, segments=7F, dots=1, frame=0 every cycle. Release -> first anode low (an=FE) appears 2 cycles after prescaler passes 0.
- Scan/decode: load value=0x89ABCDEF, dot_mask=0x01, enable=1; run 2 frames.
  - Each slot: 1 dark cycle, then 3 lit cycles.
  - an sequence FE,FD,FB,…,7F; segments 0E,06,21,46,03,08,10,00.
  - dots=0 only in slot 0.
  - frame pulses every 32 cycles.
- Mid-slot load: during digit 2 lit with value 0x00000000, load 0x00000700.
  - Next cycle segments changes 40→78; an stays FB.
- enable low for 10 cycles: an=FF, segments=7F throughout; idx keeps advancing.
  - After enable returns, the correct digit for the current idx is lit.
- Reset mid-operation: latch 0x12345678, scan to digit 5, pulse rst.
  - Outputs dark; idx restarts at 0; shadow cleared, so digit 0 shows 40.
- LEADING_ZERO_BLANK_EN defined, value 0x00000305:
  - Digits 0,1,2 show 12,40,30.
  - Digits 3..7 show 7F with their anodes still strobing.

Source files
------------

// File: rtl/sevenseg_scan_driver.sv
// -----------------------------------------------------------------------------
// sevenseg_scan_driver
//
// Display stage behind the arithmetic core. The core's result word is copied
// into shadow registers on a load strobe. The word is then shown as hex digits
// on a common-anode, time-multiplexed 7-segment display. Each digit slot lasts
// REFRESH_DIV clocks. The first BLANK_CYCLES clocks of every slot keep all
// anodes off, so the previous digit's pattern does not ghost onto the next one.
//
// Optional feature (compile-time macro LEADING_ZERO_BLANK_EN):
//   When defined, leading zero digits (digit i > 0 with every digit j >= i
//   equal to zero) show blank segments. Their anodes still strobe, so scan
//   timing does not change. Digit 0 is always shown.
//
// Ports:
//   clk       in   1         clock
//   rst       in   1         synchronous active-high reset
//   load      in   1         copy value/dot_mask into the shadow registers
//   value     in   4*DIGITS  hex word, digit i = value[4i+3:4i]
//   dot_mask  in   DIGITS    1 = decimal point lit on digit i
//   enable    in   1         0 = display dark, scanning keeps running
//   segments  out  7         {g,f,e,d,c,b,a}, active-low
//   dots      out  1         decimal point, active-low
//   an        out  DIGITS    anodes, active-low, at most one low
//   frame     out  1         one-cycle pulse after the digit index wraps to 0
//
// Every output is registered. The pins reflect the prescaler, index, shadow
// registers and enable as they stood before the previous clock edge.
// -----------------------------------------------------------------------------
module sevenseg_scan_driver #(
  parameter int DIGITS       = 8,
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dot_mask,
  input  logic                  enable,
  output logic [6:0]            segments,
  output logic                  dots,
  output logic [DIGITS-1:0]     an,
  output logic                  frame
);

  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [PW-1:0] PRESC_MAX = PW'(REFRESH_DIV - 1);
  localparam logic [PW-1:0] BLANK_LIM = PW'(BLANK_CYCLES);
  localparam logic [IW-1:0] IDX_MAX   = IW'(DIGITS - 1);

  // Hex to active-low {g,f,e,d,c,b,a} segment pattern.
  function automatic logic [6:0] f_decode(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0:    seg = 7'h40;
      4'h1:    seg = 7'h79;
      4'h2:    seg = 7'h24;
      4'h3:    seg = 7'h30;
      4'h4:    seg = 7'h19;
      4'h5:    seg = 7'h12;
      4'h6:    seg = 7'h02;
      4'h7:    seg = 7'h78;
      4'h8:    seg = 7'h00;
      4'h9:    seg = 7'h10;
      4'hA:    seg = 7'h08;
      4'hB:    seg = 7'h03;
      4'hC:    seg = 7'h46;
      4'hD:    seg = 7'h21;
      4'hE:    seg = 7'h06;
      4'hF:    seg = 7'h0E;
      default: seg = 7'h7F;
    endcase
    return seg;
  endfunction

  logic [4*DIGITS-1:0] r_value;
  logic [DIGITS-1:0]   r_dmask;
  logic [PW-1:0]       r_presc;
  logic [IW-1:0]       r_idx;
  logic [6:0]          r_segments;
  logic                r_dots;
  logic [DIGITS-1:0]   r_an;
  logic                r_frame;

  logic [3:0]          w_nibble;
  logic                w_dot;
  logic [DIGITS-1:0]   w_an;
  logic                w_lz_blank;
  logic [6:0]          w_seg;
  logic                w_dark;
  logic                w_slot_end;

  // Select the shadow nibble, dot bit and one-hot-low anode for the current index.
  always_comb begin
    w_nibble = 4'h0;
    w_dot    = 1'b0;
    w_an     = {DIGITS{1'b1}};
    for (int i = 0; i < DIGITS; i++) begin
      if (r_idx == IW'(i)) begin
        w_nibble = r_value[4*i +: 4];
        w_dot    = r_dmask[i];
        w_an[i]  = 1'b0;
      end else begin
        w_an[i]  = 1'b1;
      end
    end
  end

  // Find whether the current digit is a leading zero. Scanning from the top
  // digit downward, w_tail_zero stays set only while every digit seen so far
  // is zero.
  always_comb begin
    logic w_tail_zero;
    w_tail_zero = 1'b1;
    w_lz_blank  = 1'b0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      w_tail_zero = w_tail_zero & (r_value[4*i +: 4] == 4'h0);
      if ((r_idx == IW'(i)) && (i != 0)) begin
        w_lz_blank = w_tail_zero;
      end else begin
        w_lz_blank = w_lz_blank;
      end
    end
  end

  // Segment pattern for the lit condition.
  always_comb begin
`ifdef LEADING_ZERO_BLANK_EN
    if (w_lz_blank) begin
      w_seg = 7'h7F;
    end else begin
      w_seg = f_decode(w_nibble);
    end
`else
    w_seg = f_decode(w_nibble);
`endif
  end

  // Dark during the anti-ghost window or while disabled. The blank window
  // wins over an enable that rises on the same edge.
  assign w_dark     = (r_presc < BLANK_LIM) || !enable;
  assign w_slot_end = (r_presc == PRESC_MAX);

  // Shadow registers, scan counters and registered output pins.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_value    <= {(4*DIGITS){1'b0}};
      r_dmask    <= {DIGITS{1'b0}};
      r_presc    <= {PW{1'b0}};
      r_idx      <= {IW{1'b0}};
      r_segments <= 7'h7F;
      r_dots     <= 1'b1;
      r_an       <= {DIGITS{1'b1}};
      r_frame    <= 1'b0;
    end else begin
      if (load) begin
        r_value <= value;
        r_dmask <= dot_mask;
      end

      if (w_slot_end) begin
        r_presc <= {PW{1'b0}};
        r_idx   <= (r_idx == IDX_MAX) ? {IW{1'b0}} : r_idx + IW'(1);
      end else begin
        r_presc <= r_presc + PW'(1);
      end

      // Pulse on the edge where the index wraps to 0. The pulse is visible in
      // the cycle that follows.
      r_frame <= w_slot_end && (r_idx == IDX_MAX);

      if (w_dark) begin
        r_an       <= {DIGITS{1'b1}};
        r_segments <= 7'h7F;
        r_dots     <= 1'b1;
      end else begin
        r_an       <= w_an;
        r_segments <= w_seg;
        r_dots     <= ~w_dot;
      end
    end
  end

  assign segments = r_segments;
  assign dots     = r_dots;
  assign an       = r_an;
  assign frame    = r_frame;

endmodule

// File: tb/tb_sevenseg_scan_driver.sv
// -----------------------------------------------------------------------------
// Directed testbench for sevenseg_scan_driver (DIGITS=8, REFRESH_DIV=4,
// BLANK_CYCLES=1). Expected values are hand-derived. After edge n counted from
// reset release, the pins show the prescaler value (n-1)%4 and the index
// ((n-1)/4)%8. Outputs are sampled 1 time unit after the rising edge.
// -----------------------------------------------------------------------------
module tb_sevenseg_scan_driver;

  logic        clk = 1'b0;
  logic        rst;
  logic        load;
  logic [31:0] value;
  logic [7:0]  dot_mask;
  logic        enable;
  logic [6:0]  segments;
  logic        dots;
  logic [7:0]  an;
  logic        frame;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  sevenseg_scan_driver #(
    .DIGITS      (8),
    .REFRESH_DIV (4),
    .BLANK_CYCLES(1)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .value    (value),
    .dot_mask (dot_mask),
    .enable   (enable),
    .segments (segments),
    .dots     (dots),
    .an       (an),
    .frame    (frame)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int n);
    while (cyc < n) step();
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic [7:0] exp_an   [8] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};
  logic [6:0] scan_seg [8] = '{7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00};
`ifdef LEADING_ZERO_BLANK_EN
  logic [6:0] lz_seg   [8] = '{7'h12, 7'h40, 7'h30, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
  logic [6:0] zero_seg_d2 = 7'h7F;   // digit 2 of an all-zero word is a leading zero
  logic [6:0] zero_seg_d5 = 7'h7F;   // digits 5..7 of 0x700 are leading zeros
`else
  logic [6:0] lz_seg   [8] = '{7'h12, 7'h40, 7'h30, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};
  logic [6:0] zero_seg_d2 = 7'h40;
  logic [6:0] zero_seg_d5 = 7'h40;
`endif

  initial begin
    int p;
    int ix;
    rst      = 1'b1;
    load     = 1'b0;
    value    = 32'h0;
    dot_mask = 8'h00;
    enable   = 1'b0;

    // Reset held for three cycles: all outputs dark, no frame pulse.
    for (int k = 0; k < 3; k++) begin
      step();
      check("rst_an",    32'(an),       32'hFF);
      check("rst_seg",   32'(segments), 32'h7F);
      check("rst_dots",  32'(dots),     32'h1);
      check("rst_frame", 32'(frame),    32'h0);
    end

    // Release: dark for one cycle, then digit 0 lit with a cleared shadow.
    rst    = 1'b0;
    enable = 1'b1;
    cyc    = 0;
    step();
    check("rel_an_dark", 32'(an), 32'hFF);
    step();
    check("rel_an_first", 32'(an),       32'hFE);
    check("rel_seg_first", 32'(segments), 32'h40);

    // Re-reset, then load 0x89ABCDEF with the dot on digit 0 at release.
    rst = 1'b1;
    step();
    rst      = 1'b0;
    load     = 1'b1;
    value    = 32'h89ABCDEF;
    dot_mask = 8'h01;
    cyc      = 0;
    for (int n = 1; n <= 64; n++) begin
      step();
      if (n == 1) load = 1'b0;
      p  = (n - 1) % 4;
      ix = ((n - 1) / 4) % 8;
      if (p < 1) begin
        check($sformatf("scan_an_%0d", n),   32'(an),       32'hFF);
        check($sformatf("scan_seg_%0d", n),  32'(segments), 32'h7F);
        check($sformatf("scan_dots_%0d", n), 32'(dots),     32'h1);
      end else begin
        check($sformatf("scan_an_%0d", n),   32'(an),       32'(exp_an[ix]));
        check($sformatf("scan_seg_%0d", n),  32'(segments), 32'(scan_seg[ix]));
        check($sformatf("scan_dots_%0d", n), 32'(dots),     (ix == 0) ? 32'h0 : 32'h1);
      end
      check($sformatf("scan_frame_%0d", n), 32'(frame), (n % 32 == 0) ? 32'h1 : 32'h0);
    end

    // Mid-slot load: show a zero word, then load 0x700 while digit 2 is lit.
    load     = 1'b1;
    value    = 32'h0;
    dot_mask = 8'h00;
    step();
    load = 1'b0;
    run_to(74);
    check("mid_an_before",  32'(an),       32'hFB);
    check("mid_seg_before", 32'(segments), 32'(zero_seg_d2));
    load  = 1'b1;
    value = 32'h00000700;
    step();
    load = 1'b0;
    check("mid_an_latch",  32'(an),       32'hFB);
    check("mid_seg_latch", 32'(segments), 32'(zero_seg_d2));
    step();
    check("mid_an_after",  32'(an),       32'hFB);
    check("mid_seg_after", 32'(segments), 32'h78);

    // Enable low for 10 cycles: dark throughout while the index keeps moving.
    enable = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      step();
      check($sformatf("dis_an_%0d", k),   32'(an),       32'hFF);
      check($sformatf("dis_seg_%0d", k),  32'(segments), 32'h7F);
      check($sformatf("dis_dots_%0d", k), 32'(dots),     32'h1);
    end
    enable = 1'b1;
    step();
    check("en_back_an",  32'(an),       32'hDF);
    check("en_back_seg", 32'(segments), 32'(zero_seg_d5));

    // Reset mid-operation with 0x12345678 latched while digit 5 is lit.
    load  = 1'b1;
    value = 32'h12345678;
    step();
    load = 1'b0;
    run_to(118);
    check("pre_rst_an",  32'(an),       32'hDF);
    check("pre_rst_seg", 32'(segments), 32'h30);
    rst = 1'b1;
    step();
    check("mrst_an",    32'(an),       32'hFF);
    check("mrst_seg",   32'(segments), 32'h7F);
    check("mrst_dots",  32'(dots),     32'h1);
    check("mrst_frame", 32'(frame),    32'h0);
    rst = 1'b0;
    cyc = 0;
    step();
    check("mrst_rel_an", 32'(an), 32'hFF);
    step();
    check("mrst_d0_an",  32'(an),       32'hFE);
    check("mrst_d0_seg", 32'(segments), 32'h40);

    // Value 0x305 through a full frame. Zero digits above the 3 are blank
    // only when leading-zero blanking is built in.
    load  = 1'b1;
    value = 32'h00000305;
    step();
    load = 1'b0;
    for (int d = 0; d < 8; d++) begin
      run_to(34 + 4 * d);
      check($sformatf("lz_an_%0d", d),  32'(an),       32'(exp_an[d]));
      check($sformatf("lz_seg_%0d", d), 32'(segments), 32'(lz_seg[d]));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
